jtkcpu_idxctl: RTL and testbench



---
 rtl/jtkcpu_idxctl.sv | 171 +++++++++++++++++
 tb/tb_jtkcpu_idxctl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jtkcpu_idxctl.sv
// Indexed-addressing sequencer: postbyte/offset fetch, index-adder strobe, indirect read.
// Optional JTKCPU_IDXCTL_WB_EN adds idx_wb for auto inc/dec writeback.
module jtkcpu_idxctl (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        start,
    input  logic [15:0] pc,
    input  logic [7:0]  din,
    input  logic        mem_ok,
    input  logic [15:0] idx_addr,
    output logic [15:0] bus_addr,
    output logic        rd,
    output logic        pc_inc,
    output logic [7:0]  pbyte,
    output logic [15:0] ofs,
    output logic        idx_ret,
    output logic        idx_ld,
    output logic [15:0] ea,
    output logic        indirect,
`ifdef JTKCPU_IDXCTL_WB_EN
    output logic        idx_wb,
`endif
    output logic        busy,
    output logic        done
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_PBYTE  = 4'd1;
    localparam logic [3:0] S_OFS_HI = 4'd2;
    localparam logic [3:0] S_OFS_LO = 4'd3;
    localparam logic [3:0] S_CALC   = 4'd4;
    localparam logic [3:0] S_EAW    = 4'd5;
    localparam logic [3:0] S_IND_HI = 4'd6;
    localparam logic [3:0] S_IND_LO = 4'd7;
    localparam logic [3:0] S_DONE   = 4'd8;

    logic [3:0]  state_q, state_d;
    logic [7:0]  pbyte_q, pbyte_d;
    logic [15:0] ofs_q, ofs_d;
    logic [15:0] ea_q, ea_d;
    logic [7:0]  ptr_hi_q, ptr_hi_d;
    logic        pc_inc_q, pc_inc_d;

    function automatic logic one_byte(input logic [7:0] p);
        return ~p[7] & (p[3:0] == 4'b1000 || p[3:0] == 4'b1100);
    endfunction

    function automatic logic two_bytes(input logic [7:0] p);
        return ~p[7] & (p[3:0] == 4'b1001 || p[3:0] == 4'b1101 ||
                        p[3:0] == 4'b1111);
    endfunction

    function automatic logic ext_mode(input logic [7:0] p);
        return ~p[7] & (p[3:0] == 4'b1111);
    endfunction

    always_comb begin
        state_d  = state_q;
        pbyte_d  = pbyte_q;
        ofs_d    = ofs_q;
        ea_d     = ea_q;
        ptr_hi_d = ptr_hi_q;
        pc_inc_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_PBYTE;
            end
            S_PBYTE: begin
                if (mem_ok) begin
                    pbyte_d  = din;
                    pc_inc_d = 1'b1;
                    if (two_bytes(din))     state_d = S_OFS_HI;
                    else if (one_byte(din)) state_d = S_OFS_LO;
                    else                    state_d = S_CALC;
                end
            end
            S_OFS_HI: begin
                if (mem_ok) begin
                    ofs_d[15:8] = din;
                    pc_inc_d    = 1'b1;
                    state_d     = S_OFS_LO;
                end
            end
            S_OFS_LO: begin
                if (mem_ok) begin
                    if (one_byte(pbyte_q)) ofs_d = {{8{din[7]}}, din};
                    else                   ofs_d = {ofs_q[15:8], din};
                    pc_inc_d = 1'b1;
                    state_d  = S_CALC;
                end
            end
            S_CALC: state_d = S_EAW;
            S_EAW: begin
                ea_d    = idx_addr;
                state_d = indirect ? S_IND_HI : S_DONE;
            end
            S_IND_HI: begin
                if (mem_ok) begin
                    ptr_hi_d = din;
                    state_d  = S_IND_LO;
                end
            end
            S_IND_LO: begin
                if (mem_ok) begin
                    ea_d    = {ptr_hi_q, din};
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pbyte_q  <= 8'h00;
            ofs_q    <= 16'h0000;
            ea_q     <= 16'h0000;
            ptr_hi_q <= 8'h00;
            pc_inc_q <= 1'b0;
        end else if (cen) begin
            state_q  <= state_d;
            pbyte_q  <= pbyte_d;
            ofs_q    <= ofs_d;
            ea_q     <= ea_d;
            ptr_hi_q <= ptr_hi_d;
            pc_inc_q <= pc_inc_d;
        end
    end

    // Bus signals decode from registered state only; pc is a registered CPU value
    always_comb begin
        bus_addr = 16'h0000;
        rd       = 1'b0;
        unique case (state_q)
            S_PBYTE, S_OFS_HI, S_OFS_LO: begin
                bus_addr = pc;
                rd       = 1'b1;
            end
            S_IND_HI: begin
                bus_addr = ea_q;
                rd       = 1'b1;
            end
            S_IND_LO: begin
                bus_addr = ea_q + 16'd1;
                rd       = 1'b1;
            end
            default: begin
                bus_addr = 16'h0000;
                rd       = 1'b0;
            end
        endcase
    end

    assign pc_inc   = pc_inc_q;
    assign pbyte    = pbyte_q;
    assign ofs      = ofs_q;
    assign ea       = ea_q;
    assign indirect = ~pbyte_q[7] & pbyte_q[4];
    assign idx_ret  = (state_q == S_CALC);
    assign idx_ld   = (state_q == S_CALC) & ext_mode(pbyte_q);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);

`ifdef JTKCPU_IDXCTL_WB_EN
    assign idx_wb = (state_q == S_EAW) & ~pbyte_q[7] & (pbyte_q[3:2] == 2'b00);
`endif

endmodule

// File: tb/tb_jtkcpu_idxctl.sv
// Bench for jtkcpu_idxctl: vector table with scoreboard, plus reset/wait/cen corners.
// Stream bytes come from a per-operation table; pointer reads from a fixed memory map.
module tb_jtkcpu_idxctl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b1;
    logic        start = 1'b0;
    logic        mem_ok = 1'b1;
    logic [15:0] pc;
    logic [7:0]  din;
    logic [15:0] idx_addr = 16'h0000;
    logic [15:0] bus_addr;
    logic        rd;
    logic        pc_inc;
    logic [7:0]  pbyte;
    logic [15:0] ofs;
    logic        idx_ret;
    logic        idx_ld;
    logic [15:0] ea;
    logic        indirect;
    logic        busy;
    logic        done;
`ifdef JTKCPU_IDXCTL_WB_EN
    logic        idx_wb;
`endif

    jtkcpu_idxctl dut (
        .clk(clk), .rst(rst), .cen(cen), .start(start),
        .pc(pc), .din(din), .mem_ok(mem_ok), .idx_addr(idx_addr),
        .bus_addr(bus_addr), .rd(rd), .pc_inc(pc_inc),
        .pbyte(pbyte), .ofs(ofs), .idx_ret(idx_ret),
        .idx_ld(idx_ld), .ea(ea), .indirect(indirect),
`ifdef JTKCPU_IDXCTL_WB_EN
        .idx_wb(idx_wb),
`endif
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  pb, b1, b2;
        logic [15:0] ia, e, o;
        bit          co;
        int          pcn, lat;
        bit          ld, ind;
        int          wat, wn, cat, cn, rat;
    } vec_t;

    vec_t tv[14];
    vec_t sbq[$];
    int checks = 0;
    int errors = 0;

    logic [7:0]  sb0 = 8'h00, sb1 = 8'h00, sb2 = 8'h00;
    int          k = 0;
    int          kbase = 0;
    logic [15:0] pc_tb = 16'h0100;

    assign pc = pc_tb;

    function automatic logic [7:0] memrd(input logic [15:0] a);
        if (a == 16'hFFFF) return 8'hAB;
        if (a == 16'h0000) return 8'hCD;
        return a[7:0] ^ 8'h5A;
    endfunction

    always_comb begin
        din = memrd(bus_addr);
        if (bus_addr == pc_tb) begin
            if (k - kbase == 0)      din = sb0;
            else if (k - kbase == 1) din = sb1;
            else if (k - kbase == 2) din = sb2;
            else                     din = 8'hEE;
        end
    end

    always @(posedge clk) begin
        if (cen && pc_inc) pc_tb <= pc_tb + 16'd1;
        if (cen && !rst && rd && mem_ok && bus_addr == pc_tb) k <= k + 1;
    end

    function automatic vec_t mk(
        input logic [7:0] pb, b1, b2, input logic [15:0] ia, e, o,
        input bit co, input int pcn, lat, input bit ld, ind,
        input int wat, wn, cat, cn, rat);
        vec_t v;
        v.pb = pb; v.b1 = b1; v.b2 = b2; v.ia = ia; v.e = e; v.o = o;
        v.co = co; v.pcn = pcn; v.lat = lat; v.ld = ld; v.ind = ind;
        v.wat = wat; v.wn = wn; v.cat = cat; v.cn = cn; v.rat = rat;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] snapsig();
        return 64'({rd, pc_inc, idx_ret, busy, done, bus_addr, ofs, ea});
    endfunction

    function automatic logic [63:0] allout();
        return 64'({bus_addr, rd, pc_inc, pbyte, ofs, idx_ret, idx_ld,
                    ea, indirect, busy, done});
    endfunction

    task automatic run(input vec_t v);
        int n, pcn, retn, wbn, frz, wl;
        bit ld, cen_done, w_done, r_done, got;
        logic [15:0] ref_a;
        logic [63:0] snap;
        vec_t e;
        n = 0; pcn = 0; retn = 0; wbn = 0; frz = 0; wl = 0;
        ld = 0; cen_done = 0; w_done = 0; r_done = 0; got = 0;
        ref_a = 16'h0; snap = 64'h0;
        sb0 = v.pb; sb1 = v.b1; sb2 = v.b2; kbase = k;
        idx_addr = v.ia; mem_ok = 1'b1; cen = 1'b1;
        start = 1'b1;
        sbq.push_back(v);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'(1));
        for (int c = 0; c < 80 && !got; c++) begin
            @(posedge clk);
            if (cen) n++;
            @(negedge clk);
            if (frz > 0) begin
                chk("cen_freeze", snapsig(), snap);
                frz--;
                if (frz == 0) cen = 1'b1;
            end else if (v.cn > 0 && !cen_done && n == v.cat) begin
                cen = 1'b0; frz = v.cn; cen_done = 1; snap = snapsig();
            end
            if (wl > 0) begin
                wl--;
                if (wl == v.wn - 1) ref_a = bus_addr;
                else chk("wait_hold_addr", 64'(bus_addr), 64'(ref_a));
                chk("wait_hold_rd_pcinc", 64'({rd, pc_inc}), 64'(2'b10));
                if (wl == 0) mem_ok = 1'b1;
            end else if (v.wn > 0 && !w_done && n == v.wat) begin
                mem_ok = 1'b0; wl = v.wn; w_done = 1;
            end
            start = 1'b0;
            if (v.rat > 0 && !r_done && n == v.rat) begin
                start = 1'b1; r_done = 1;
            end
            if (cen) begin
                if (pc_inc) pcn++;
                if (idx_ret) begin retn++; ld = idx_ld; end
`ifdef JTKCPU_IDXCTL_WB_EN
                if (idx_wb) wbn++;
`endif
            end
            if (done) got = 1;
        end
        start = 1'b0; mem_ok = 1'b1; cen = 1'b1;
        e = sbq.pop_front();
        if (!got) begin
            checks++; errors++;
            $display("FAIL timeout pbyte=%h actual=no_done required=done", e.pb);
        end else begin
            chk("latency", 64'(n), 64'(e.lat));
            chk("ea", 64'(ea), 64'(e.e));
            if (e.co) chk("ofs", 64'(ofs), 64'(e.o));
            chk("pbyte", 64'(pbyte), 64'(e.pb));
            chk("pc_inc_count", 64'(pcn), 64'(e.pcn));
            chk("idx_ret_count", 64'(retn), 64'(1));
            chk("idx_ld", 64'(ld), 64'(e.ld));
            chk("indirect", 64'(indirect), 64'(e.ind));
`ifdef JTKCPU_IDXCTL_WB_EN
            chk("idx_wb_count", 64'(wbn),
                64'((!e.pb[7] && e.pb[3:0] <= 4'd3) ? 1 : 0));
`endif
        end
        @(posedge clk);
        @(negedge clk);
        chk("idle_after_done", 64'({busy, done}), 64'(0));
    endtask

    task automatic rst_mid();
        sb0 = 8'h19; sb1 = 8'h12; sb2 = 8'h34; kbase = k;
        idx_addr = 16'hFFFF; mem_ok = 1'b1; cen = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("ind_hi_addr", 64'({rd, bus_addr}), 64'({1'b1, 16'hFFFF}));
        @(posedge clk);
        @(negedge clk);
        chk("ind_lo_wrap_addr", 64'({rd, bus_addr}), 64'({1'b1, 16'h0000}));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("reset_mid_read", allout(), 64'(0));
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("idle_after_reset", 64'({busy, rd}), 64'(0));
    endtask

    initial begin
        tv[0]  = mk(8'h85, 8'h00, 8'h00, 16'h1234, 16'h1234, 16'h0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        tv[1]  = mk(8'h08, 8'hF0, 8'h00, 16'h2000, 16'h2000, 16'hFFF0, 1, 2, 4, 0, 0, 0, 0, 0, 0, 0);
        tv[2]  = mk(8'h19, 8'h12, 8'h34, 16'hFFFF, 16'hABCD, 16'h1234, 1, 3, 7, 0, 1, 0, 0, 0, 0, 0);
        tv[3]  = mk(8'h0F, 8'h40, 8'h00, 16'h4000, 16'h4000, 16'h4000, 1, 3, 5, 1, 0, 0, 0, 0, 0, 0);
        tv[4]  = mk(8'h0C, 8'h7F, 8'h00, 16'h1111, 16'h1111, 16'h007F, 1, 2, 4, 0, 0, 0, 0, 0, 0, 0);
        tv[5]  = mk(8'h99, 8'h00, 8'h00, 16'h2222, 16'h2222, 16'h0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        tv[6]  = mk(8'h14, 8'h00, 8'h00, 16'h0300, 16'h5A5B, 16'h0, 0, 1, 5, 0, 1, 0, 0, 0, 0, 0);
        tv[7]  = mk(8'h1D, 8'h80, 8'h01, 16'h05A0, 16'hFAFB, 16'h8001, 1, 3, 7, 0, 1, 0, 0, 0, 0, 0);
        tv[8]  = mk(8'h1F, 8'h05, 8'h00, 16'h0500, 16'h5A5B, 16'h0500, 1, 3, 7, 1, 1, 0, 0, 0, 0, 0);
        tv[9]  = mk(8'h00, 8'h00, 8'h00, 16'h3333, 16'h3333, 16'h0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        tv[10] = mk(8'h04, 8'h00, 8'h00, 16'h4444, 16'h4444, 16'h0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        tv[11] = mk(8'h09, 8'h12, 8'h34, 16'h5555, 16'h5555, 16'h1234, 1, 3, 8, 0, 0, 1, 3, 0, 0, 0);
        tv[12] = mk(8'h08, 8'hF0, 8'h00, 16'h6666, 16'h6666, 16'hFFF0, 1, 2, 4, 0, 0, 0, 0, 1, 3, 0);
        tv[13] = mk(8'h19, 8'h12, 8'h34, 16'hFFFF, 16'hABCD, 16'h1234, 1, 3, 9, 0, 1, 5, 2, 0, 0, 0);

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_values", allout(), 64'(0));
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("idle_no_start", 64'({busy, rd, done}), 64'(0));

        for (int i = 0; i < 14; i++) run(tv[i]);

        begin
            vec_t r;
            r = tv[3];
            r.rat = 2;
            run(r);
        end

        rst_mid();
        run(tv[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
